// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Program counter for the fetch stage. It issues instruction-fetch addresses
// to instruction memory over a valid/ready handshake. The unit boots from a
// configurable reset vector and accepts prioritised redirects, where a trap
// wins over a branch. A branch to a misaligned target parks the unit in a
// FAULT state. Only a trap redirect releases it.
//
// Parameters
//   XLEN          address / PC width in bits
//   RESET_VECTOR  PC value loaded on reset
//   IALIGN        instruction alignment: 32 (low 2 bits checked) or 16 (bit 0)
//   CNT_W         width of the saturating accepted-request counter
//
// Ports
//   clk               clock; all state updates on the rising edge
//   reset             synchronous, active-high reset
//   stall             fetch-side hold: drops fetch_valid, PC does not advance
//   fetch_ready       instruction memory accepts the current request
//   branch_taken      branch/jump redirect request
//   branch_target     branch/jump target address
//   trap_taken        trap/exception redirect request (highest priority)
//   trap_target       trap handler address (low bits are forced aligned)
//   pc                current fetch address (registered)
//   fetch_valid       fetch request valid; pc is the request address
//   misaligned_fault  high while parked in FAULT
//   fault_addr        offending branch target captured on fault entry
//   req_count         number of accepted requests, saturating at all-ones
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = 32,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             trap_taken,
  input  logic [XLEN-1:0]  trap_target,
  output logic [XLEN-1:0]  pc,
  output logic             fetch_valid,
  output logic             misaligned_fault,
  output logic [XLEN-1:0]  fault_addr,
  output logic [CNT_W-1:0] req_count
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  // Low address bits that must be zero for a legal instruction address.
  localparam logic [1:0]      ALIGN_MASK = (IALIGN == 16) ? 2'b01 : 2'b11;
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  state_t          state;
  logic            fire;
  logic            misaligned;
  logic            cnt_sat;
  logic [XLEN-1:0] trap_pc;

  assign fetch_valid = (state == ST_RUN) && !stall;
  assign fire        = fetch_valid && fetch_ready;
  assign misaligned  = |(branch_target[1:0] & ALIGN_MASK);
  assign cnt_sat     = &req_count;

  // A trap handler address is used with its alignment bits cleared. A trap
  // never faults.
  assign trap_pc = {trap_target[XLEN-1:2], trap_target[1:0] & ~ALIGN_MASK};

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its peers, whatever the statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_BOOT;
      pc               <= RESET_VECTOR;
      misaligned_fault <= 1'b0;
      fault_addr       <= '0;
      req_count        <= '0;
    end else begin
      // fire can only be high in RUN. An accepted request is counted even
      // when a redirect in the same cycle discards its pc+4.
      if (fire && !cnt_sat) begin
        req_count <= req_count + CNT_W'(1);
      end

      unique case (state)
        ST_BOOT: begin
          state <= ST_RUN;
        end

        ST_RUN: begin
          // Redirects act regardless of stall. They may withdraw a pending,
          // unaccepted request.
          if (trap_taken) begin
            pc <= trap_pc;
          end else if (branch_taken && misaligned) begin
            fault_addr       <= branch_target;
            misaligned_fault <= 1'b1;
            state            <= ST_FAULT;
          end else if (branch_taken) begin
            pc <= branch_target;
          end else if (fire) begin
            pc <= pc + PC_STEP;
          end
        end

        ST_FAULT: begin
          // Branches are ignored here. fault_addr keeps the culprit address.
          if (trap_taken) begin
            pc               <= trap_pc;
            misaligned_fault <= 1'b0;
            state            <= ST_RUN;
          end
        end

        default: begin
          state <= ST_BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Self-checking bench for fetch_pc_unit. Two instances share one stimulus:
//   dut_a  IALIGN=32, CNT_W=16
//   dut_b  IALIGN=16, CNT_W=4
// Both use RESET_VECTOR 0x1000. A table of directed vectors checks dut_a
// cycle by cycle. Hand-written sequences cover 16-bit alignment, PC wrap,
// counter saturation and reset mid-stream. A randomized phase follows.
// Every cycle, both instances are also compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_fetch_pc_unit;

  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset, stall, fetch_ready, branch_taken, trap_taken;
  logic [31:0] branch_target, trap_target;

  logic [31:0] pc_a, fa_a, pc_b, fa_b;
  logic        fv_a, flt_a, fv_b, flt_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(32), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .trap_taken(trap_taken), .trap_target(trap_target),
    .pc(pc_a), .fetch_valid(fv_a), .misaligned_fault(flt_a),
    .fault_addr(fa_a), .req_count(cnt_a)
  );

  fetch_pc_unit #(.XLEN(32), .RESET_VECTOR(RV), .IALIGN(16), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .stall(stall), .fetch_ready(fetch_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .trap_taken(trap_taken), .trap_target(trap_target),
    .pc(pc_b), .fetch_valid(fv_b), .misaligned_fault(flt_b),
    .fault_addr(fa_b), .req_count(cnt_b)
  );

  // ---------------------------------------------------------------------------
  // Behavioural reference model. It tracks an unbounded fire count and clamps
  // it to the counter maximum only when compared. Alignment uses modulo
  // arithmetic on the instruction size in bytes.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          running;   // boot cycle done
    bit          faulted;
    logic [31:0] pc;
    logic [31:0] faddr;
    longint      fires;
  } mdl_t;

  mdl_t   m [2];
  bit     mvalid = 1'b0;
  int     align_bytes [2] = '{4, 2};
  longint cnt_max     [2] = '{65535, 15};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step_model();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m[i].running = 1'b0;
        m[i].faulted = 1'b0;
        m[i].pc      = RV;
        m[i].faddr   = '0;
        m[i].fires   = 0;
      end else if (!m[i].running) begin
        m[i].running = 1'b1;
      end else if (m[i].faulted) begin
        if (trap_taken) begin
          m[i].pc      = trap_target - (trap_target % align_bytes[i]);
          m[i].faulted = 1'b0;
        end
      end else begin
        if (!stall && fetch_ready) m[i].fires++;
        if (trap_taken)
          m[i].pc = trap_target - (trap_target % align_bytes[i]);
        else if (branch_taken && (branch_target % align_bytes[i]) != 0) begin
          m[i].faulted = 1'b1;
          m[i].faddr   = branch_target;
        end else if (branch_taken)
          m[i].pc = branch_target;
        else if (!stall && fetch_ready)
          m[i].pc = m[i].pc + 32'd4;
      end
    end
    if (reset) mvalid = 1'b1;
  endtask

  task automatic compare_model();
    longint ec [2];
    bit     ev [2];
    if (!mvalid) return;
    for (int i = 0; i < 2; i++) begin
      ec[i] = (m[i].fires > cnt_max[i]) ? cnt_max[i] : m[i].fires;
      ev[i] = m[i].running && !m[i].faulted && !stall;
    end
    check("a.pc",    pc_a,  m[0].pc);
    check("a.valid", fv_a,  ev[0]);
    check("a.fault", flt_a, m[0].faulted);
    check("a.faddr", fa_a,  m[0].faddr);
    check("a.count", cnt_a, ec[0]);
    check("b.pc",    pc_b,  m[1].pc);
    check("b.valid", fv_b,  ev[1]);
    check("b.fault", flt_b, m[1].faulted);
    check("b.faddr", fa_b,  m[1].faddr);
    check("b.count", cnt_b, ec[1]);
  endtask

  // Compare against the model mid-cycle, then advance one clock. Returns 1 ns
  // after the edge, when registered outputs have settled.
  task automatic tick_now();
    compare_model();
    @(posedge clk);
    step_model();
    #1;
  endtask

  task automatic tick();
    #2;
    tick_now();
  endtask

  task automatic drive(input bit rst, input bit stl, input bit rdy,
                       input bit br, input logic [31:0] bt,
                       input bit tr, input logic [31:0] tt);
    reset = rst; stall = stl; fetch_ready = rdy;
    branch_taken = br; branch_target = bt;
    trap_taken = tr; trap_target = tt;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors for dut_a. Each row gives the inputs held for one cycle
  // and the outputs expected during that cycle, before the closing edge.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit          rst, stl, rdy, br;
    logic [31:0] bt;
    bit          tr;
    logic [31:0] tt;
    bit          chk;
    logic [31:0] e_pc;
    bit          e_fv, e_flt;
    logic [31:0] e_fa;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    //                rst stl rdy br  bt             tr  tt             chk pc             fv  flt fa             cnt
    tbl.push_back(vec_t'{1, 0, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0, 0, 32'h0,          16'd0});
    tbl.push_back(vec_t'{1, 0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h1000,       0, 0, 32'h0,          16'd0});
    tbl.push_back(vec_t'{1, 0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h1000,       0, 0, 32'h0,          16'd0});
    tbl.push_back(vec_t'{0, 0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h1000,       0, 0, 32'h0,          16'd0}); // BOOT
    tbl.push_back(vec_t'{0, 0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h1000,       1, 0, 32'h0,          16'd0});
    tbl.push_back(vec_t'{0, 0, 1, 0, 32'h0,          0, 32'h0,          1, 32'h1004,       1, 0, 32'h0,          16'd1});
    for (int i = 0; i < 4; i++)  // memory not ready
      tbl.push_back(vec_t'{0, 0, 0, 0, 32'h0,        0, 32'h0,          1, 32'h1008,       1, 0, 32'h0,          16'd2});
    for (int i = 0; i < 2; i++)  // stalled
      tbl.push_back(vec_t'{0, 1, 1, 0, 32'h0,        0, 32'h0,          1, 32'h1008,       0, 0, 32'h0,          16'd2});
    tbl.push_back(vec_t'{0, 0, 0, 1, 32'h2002,       0, 32'h0,          1, 32'h1008,       1, 0, 32'h0,          16'd2}); // misaligned
    tbl.push_back(vec_t'{0, 0, 1, 1, 32'h4000,       0, 32'h0,          1, 32'h1008,       0, 1, 32'h2002,       16'd2}); // ignored
    tbl.push_back(vec_t'{0, 0, 1, 0, 32'h0,          1, 32'h0103,       1, 32'h1008,       0, 1, 32'h2002,       16'd2}); // trap exit
    tbl.push_back(vec_t'{0, 0, 0, 1, 32'h0003,       1, 32'h0200,       1, 32'h0100,       1, 0, 32'h2002,       16'd2}); // trap wins
    tbl.push_back(vec_t'{0, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0200,       1, 0, 32'h2002,       16'd2});
    tbl.push_back(vec_t'{0, 0, 1, 1, 32'h5000,       0, 32'h0,          1, 32'h0200,       1, 0, 32'h2002,       16'd2}); // branch + fire
    tbl.push_back(vec_t'{0, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h5000,       1, 0, 32'h2002,       16'd3});

    foreach (tbl[k]) begin
      drive(tbl[k].rst, tbl[k].stl, tbl[k].rdy, tbl[k].br, tbl[k].bt, tbl[k].tr, tbl[k].tt);
      #2;
      if (tbl[k].chk) begin
        check($sformatf("vec%0d.pc", k),    pc_a,  tbl[k].e_pc);
        check($sformatf("vec%0d.valid", k), fv_a,  tbl[k].e_fv);
        check($sformatf("vec%0d.fault", k), flt_a, tbl[k].e_flt);
        check($sformatf("vec%0d.faddr", k), fa_a,  tbl[k].e_fa);
        check($sformatf("vec%0d.count", k), cnt_a, tbl[k].e_cnt);
      end
      tick_now();
    end

    // 16-bit alignment: 0x3002 is legal for dut_b and faults dut_a.
    drive(0, 0, 0, 1, 32'h3002, 0, 32'h0);
    tick();
    check("ialign16.pc",    pc_b,  32'h3002);
    check("ialign16.fault", flt_b, 1'b0);
    check("ialign32.fault", flt_a, 1'b1);
    check("ialign32.faddr", fa_a,  32'h3002);
    drive(0, 0, 0, 0, 32'h0, 1, 32'h0);
    tick();

    // PC wrap at the top of the address space.
    drive(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    tick();
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0);
    tick();
    check("wrap.a.pc", pc_a, 32'h0);
    check("wrap.b.pc", pc_b, 32'h0);

    // 20 back-to-back fires: the 4-bit counter saturates, the 16-bit one does not.
    for (int i = 0; i < 20; i++) tick();
    check("sat.b.count", cnt_b, 4'hF);
    check("sat.a.count", cnt_a, 16'd24);

    // Reset in the middle of a fire stream.
    drive(1, 0, 1, 0, 32'h0, 0, 32'h0);
    tick();
    check("rst.a.pc",    pc_a,  RV);
    check("rst.a.valid", fv_a,  1'b0);
    check("rst.a.fault", flt_a, 1'b0);
    check("rst.a.faddr", fa_a,  32'h0);
    check("rst.a.count", cnt_a, 16'd0);
    check("rst.b.count", cnt_b, 4'd0);
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0);
    tick();

    // Randomized phase, checked against the model every cycle.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] bt, tt;
      bt = $urandom;
      tt = $urandom;
      if ($urandom_range(1, 0) == 1) bt = bt & 32'hFFFF_FFFC;
      if ($urandom_range(3, 0) == 0) bt = 32'hFFFF_FFFC;
      drive($urandom_range(59, 0) == 0, $urandom_range(4, 0) == 0,
            $urandom_range(1, 0) == 1,  $urandom_range(5, 0) == 0, bt,
            $urandom_range(9, 0) == 0,  tt);
      tick();
    end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
